dmem_bus_bridge: RTL and testbench



---
 rtl/dmem_bridge_pkg.sv | 37 +++
 rtl/dmem_bus_bridge_timeout_ctr.sv | 46 ++++
 rtl/dmem_bus_bridge.sv | 180 ++++++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dmem_bridge_pkg
// Shared definitions for the data-memory bus bridge:
//   - state_e        : bridge FSM state encoding (IDLE / REQ / DONE)
//   - MISALIGN_MASK  : byte-offset bits that must be zero for a word access
//   - clog2()        : ceiling log2 for elaboration-time sizing
//   - ctr_width()    : width of the timeout counter for a given TIMEOUT
// -----------------------------------------------------------------------------
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Any set bit under this mask means the access is not word aligned.
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // The counter must be able to represent 0..TIMEOUT.
  function automatic int ctr_width(input int timeout);
    return clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_timeout_ctr.sv
// -----------------------------------------------------------------------------
// dmem_timeout_ctr
// Load / clear / increment counter measuring how long the bridge has been
// waiting for a bus acknowledge. o_tc flags the last permitted wait cycle.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   i_clr       in   clear counter to zero (highest priority)
//   i_load      in   load i_load_val
//   i_load_val  in   value to load
//   i_inc       in   increment by one
//   o_tc        out  counter == TIMEOUT-1
// -----------------------------------------------------------------------------
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_inc,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
// Turns the single-cycle core's load/store port into a request/acknowledge
// transaction on a wait-stated data bus, stalling the core until the bus
// completes, the access times out, or it is rejected as misaligned.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   core_rd/core_wr   load / store request from the current instruction
//   core_addr         byte address (ALU result)
//   core_wdata        store data
//   core_rdata        held load data to the writeback mux
//   core_stall        core must hold PC/inputs and suppress RegWrite
//   core_err          sticky error (timeout, misaligned, slave error)
//   err_clr           clears core_err (a simultaneous new error wins)
//   bus_req/bus_we    transaction valid / write strobe
//   bus_addr          word-aligned address
//   bus_wdata         write data
//   bus_ack           one-cycle completion pulse
//   bus_rdata/bus_err read data and slave error, valid with bus_ack
// -----------------------------------------------------------------------------
module dmem_bus_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,  // only 32 is supported
  parameter int TIMEOUT = 16   // legal range 1..255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              core_err,
  input  logic              err_clr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);

  localparam int CNT_W = ctr_width(TIMEOUT);

  state_e            r_state;
  state_e            w_next;

  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_core_rdata;
  logic              r_core_err;

  logic              w_access;
  logic              w_misaligned;
  logic              w_start;
  logic              w_mis_hit;
  logic              w_ack_hit;
  logic              w_timeout;
  logic              w_err_set;
  logic              w_tc;

  assign w_access     = core_rd | core_wr;
  assign w_misaligned = (core_addr[1:0] & MISALIGN_MASK) != 2'b00;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and event decode
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_mis_hit = 1'b0;
    w_ack_hit = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            w_mis_hit = 1'b1;
            w_next    = DONE;
          end else begin
            w_start = 1'b1;
            w_next  = REQ;
          end
        end
      end
      REQ: begin
        // An ack on the terminal-count cycle still completes normally.
        if (bus_ack) begin
          w_ack_hit = 1'b1;
          w_next    = DONE;
        end else if (w_tc) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_err_set = w_mis_hit | w_timeout | (w_ack_hit & bus_err);

  dmem_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (r_state == DONE),
    .i_load     (w_start),
    .i_load_val ({CNT_W{1'b0}}),
    .i_inc      (r_state == REQ),
    .o_tc       (w_tc)
  );

  // Bus request, latched transaction and core-facing results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_core_rdata <= '0;
      r_core_err   <= 1'b0;
    end else begin
      // Latched copies drive the bus so core inputs may wander during REQ.
      if (w_start) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= core_wr;
        r_bus_addr  <= {core_addr[ADDR_W-1:2], 2'b00};
        r_bus_wdata <= core_wdata;
      end
      if (w_ack_hit | w_timeout) begin
        r_bus_req <= 1'b0;
      end

      // Read data is only replaced by completing reads; writes leave it held.
      if (w_ack_hit & ~r_bus_we) begin
        r_core_rdata <= bus_rdata;
      end else if ((w_timeout & ~r_bus_we) | (w_mis_hit & ~core_wr)) begin
        r_core_rdata <= '0;
      end

      if (w_err_set) begin
        r_core_err <= 1'b1;
      end else if (err_clr) begin
        r_core_err <= 1'b0;
      end
    end
  end

  // Gated by rst_n so the stall drops immediately when reset is asserted.
  assign core_stall = rst_n & (((r_state == IDLE) & w_access) | (r_state == REQ));

  assign core_rdata = r_core_rdata;
  assign core_err   = r_core_err;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_bridge
// Directed bench for dmem_bus_bridge (TIMEOUT=4). A reference model computes
// the expected read data / error flag of each access and pushes it into a
// scoreboard queue when the access is driven; it is popped and compared when
// the bridge reaches DONE. Bus-side signals are checked every REQ cycle.
// -----------------------------------------------------------------------------
module tb_dmem_bus_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_rd = 1'b0;
  logic        core_wr = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        err_clr = 1'b0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  dmem_bus_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_rd    (core_rd),
    .core_wr    (core_wr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .core_err   (core_err),
    .err_clr    (err_clr),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Enters and leaves #1 after a rising edge with the bridge in IDLE.
  // waits < 0 means the slave never acknowledges.
  task automatic access(input string tag, input bit rd_in, input bit wr_in,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd_val,
                        input bit berr, input bit clr);
    bit   mis;
    bit   tmo;
    bit   acked;
    int   n;
    exp_t e;
    exp_t got;
    mis = (addr[1:0] != 2'b00);
    tmo = !mis && (waits < 0 || waits >= TMO);
    if (clr) m_err = 1'b0;
    if (!wr_in) m_rdata = (mis || tmo) ? 32'h0 : rd_val;
    if (mis || tmo || berr) m_err = 1'b1;
    e.rdata = m_rdata;
    e.err   = m_err;
    e.tag   = tag;
    sb.push_back(e);

    core_rd = rd_in; core_wr = wr_in; core_addr = addr; core_wdata = wd; err_clr = clr;
    @(negedge clk);
    chk({tag, "_idle_stall"}, core_stall, 1);
    chk({tag, "_idle_req"}, bus_req, 0);
    @(posedge clk); #1;
    err_clr = 1'b0;

    if (!mis) begin
      n = 0;
      acked = 1'b0;
      while (!acked && n < TMO) begin
        if (n == 1) begin
          core_addr  = ~addr;
          core_wdata = ~wd;
        end
        bus_ack   = (n == waits);
        bus_err   = (n == waits) && berr;
        bus_rdata = (n == waits) ? rd_val : (32'hA5A5_0000 + n);
        @(negedge clk);
        chk({tag, "_req"}, bus_req, 1);
        chk({tag, "_addr"}, bus_addr, addr);
        chk({tag, "_we"}, bus_we, wr_in);
        chk({tag, "_wdata"}, bus_wdata, wd);
        chk({tag, "_req_stall"}, core_stall, 1);
        acked = bus_ack;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        bus_err = 1'b0;
        n++;
      end
    end

    // DONE: a stray ack here must be ignored
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hBADB_AD00;
    @(negedge clk);
    chk({tag, "_done_stall"}, core_stall, 0);
    chk({tag, "_done_req"}, bus_req, 0);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      got = sb.pop_front();
      chk({got.tag, "_rdata"}, core_rdata, got.rdata);
      chk({got.tag, "_err"}, core_err, got.err);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_err = 1'b0;
    core_rd = 1'b0; core_wr = 1'b0;
    @(negedge clk);
    chk({tag, "_after_stall"}, core_stall, 0);
    chk({tag, "_after_req"}, bus_req, 0);
    chk({tag, "_after_rdata"}, core_rdata, m_rdata);
    chk({tag, "_after_err"}, core_err, m_err);
    @(posedge clk); #1;
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    m_err = 1'b0;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk(tag, core_err, m_err);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with a pending load to show the stall is held low
    core_rd = 1'b1;
    #2;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_core_err", core_err, 0);
    chk("rst_core_stall", core_stall, 0);
    core_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    @(negedge clk);
    chk("idle_transparent_stall", core_stall, 0);
    chk("idle_transparent_req", bus_req, 0);
    @(posedge clk); #1;

    access("rd0ws", 1, 0, 32'h40, 32'h0, 0, 32'hDEADBEEF, 0, 0);
    access("wr3ws", 0, 1, 32'h80, 32'h12345678, 3, 32'h0, 0, 0);
    access("rd_tc_ack", 1, 0, 32'h44, 32'h0, TMO - 1, 32'h55, 0, 0);
    access("rd_slverr", 1, 0, 32'h48, 32'h0, 1, 32'hCAFE0001, 1, 0);
    clear_err("clr_after_slverr");
    access("rd_misal", 1, 0, 32'h41, 32'h0, 0, 32'h0, 0, 0);
    clear_err("clr_after_misal");
    access("rdwr_both", 1, 1, 32'h90, 32'h0BADF00D, 2, 32'h0, 0, 0);
    access("rd_timeout", 1, 0, 32'h100, 32'h0, -1, 32'h0, 0, 0);

    // Late ack after the timeout, bridge back in IDLE
    bus_ack = 1'b1; bus_rdata = 32'h77;
    @(negedge clk);
    chk("late_ack_stall", core_stall, 0);
    chk("late_ack_req", bus_req, 0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", core_rdata, m_rdata);
    chk("late_ack_err", core_err, m_err);
    @(posedge clk); #1;
    clear_err("clr_after_timeout");

    access("rd_fill", 1, 0, 32'h104, 32'h0, 0, 32'h13579BDF, 0, 0);
    access("wr_misal_clr", 0, 1, 32'h86, 32'h11111111, 0, 32'h0, 0, 1);

    // Reset in the middle of a REQ
    core_rd = 1'b1; core_addr = 32'h200;
    @(posedge clk); #1;
    chk("midrst_pre_req", bus_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", bus_req, 0);
    chk("midrst_stall", core_stall, 0);
    chk("midrst_err", core_err, 0);
    chk("midrst_rdata", core_rdata, 0);
    m_rdata = '0;
    m_err = 1'b0;
    core_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access("rd_post_rst", 1, 0, 32'h40, 32'h0, 2, 32'h0F0F0F0F, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
